fetch_mem_ctrl: RTL
===================

FETCH_MEM_CTRL -- requirements
Module: fetch_mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, meaning memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning instruction/data word width.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 The block SHALL have port run, input, 1, enable for fetching from IDLE.
REQ-006 The block SHALL have these memory-side ports:
- mem_addr, output, ADDR_W, memory address.
- mem_rd, output, 1, read request.
- mem_wr, output, 1, write request.
- mem_wdata, output, DATA_W, write data.
- mem_rdata, input, DATA_W, read data.
- mem_rdy, input, 1, access complete.
REQ-007 The block SHALL have these architectural-state ports:
- pc, output, ADDR_W, program counter.
- ir, output, DATA_W, instruction register.
REQ-008 The block SHALL have these execute-FSM ports:
- exec_start, output, 1, one-cycle pulse that starts execution.
- exec_done, input, 1, execution complete.
REQ-009 The block SHALL have these load/store ports:
- ls_req, input, 1, load/store request.
- ls_we, input, 1, 1 = store.
- ls_addr, input, ADDR_W, load/store address.
- ls_wdata, input, DATA_W, store data.
- ls_rdata, output, DATA_W, load result.
- ls_done, output, 1, one-cycle pulse marking load/store complete.
REQ-010 The block SHALL have port halted, output, 1, high while in HALT.

Function
REQ-011 The block SHALL implement states IDLE, FETCH, EXEC, MEM and HALT.
REQ-012 In IDLE the block SHALL go to FETCH on the first edge with run=1, and otherwise hold.
REQ-013 FETCH behaviour:
- The block SHALL drive mem_rd=1 and mem_addr=pc, held stable until mem_rdy=1.
- On the mem_rdy cycle it SHALL load ir<=mem_rdata and pc<=pc+1, wrapping modulo 2^ADDR_W, then go to EXEC.
REQ-014 The block SHALL assert exec_start for exactly the first cycle of each EXEC entry from FETCH, and never on re-entry from MEM.
REQ-015 EXEC behaviour:
- With ls_req=1, the block SHALL latch ls_we/ls_addr/ls_wdata and go to MEM.
- Otherwise, with exec_done=1, it SHALL go to FETCH if run=1, else to IDLE.
- ls_req SHALL take priority; an exec_done in the same cycle SHALL be ignored.
REQ-016 MEM behaviour:
- The block SHALL drive mem_addr=latched address, with mem_wr=latched we and mem_rd=!latched we, and mem_wdata=latched data on stores, held stable until mem_rdy=1.
- On the mem_rdy cycle it SHALL capture ls_rdata<=mem_rdata (loads only), pulse ls_done on the next cycle and return to EXEC.
REQ-017 mem_rd and mem_wr SHALL never be high together and SHALL be 0 in IDLE, EXEC and HALT.
REQ-018 Zero-wait memory (mem_rdy on the first request cycle) SHALL give a FETCH of 1 cycle and a MEM of 1 cycle, with exec_start one cycle after the fetch mem_rdy cycle.
REQ-019 mem_rdy outside FETCH/MEM SHALL be ignored.
REQ-020 HALT SHALL be exited only by reset.

Reset
REQ-021 On reset the block SHALL set state=IDLE, pc=0, ir=0, ls_rdata=0, latched load/store fields=0, and all outputs 0 (mem_rd, mem_wr, exec_start, ls_done, halted).
REQ-022 Reset SHALL override every other input, including mid-FETCH or mid-MEM; requests SHALL drop on the cycle after the reset edge, and a pending mem_rdy SHALL be discarded.

Configuration
REQ-023 With FETCH_HALT_EN defined, a fetched word whose bits [DATA_W-1:DATA_W-3]==3'b111 SHALL still load ir and increment pc, but SHALL go to HALT with halted=1 and no exec_start.
REQ-024 Without FETCH_HALT_EN, opcode 3'b111 SHALL be treated as an ordinary instruction, HALT SHALL be unreachable and halted SHALL be tied 0.

Structure
REQ-025 A shared package SHALL hold:
- the state enum;
- the HALT opcode constant 3'b111;
- the default ADDR_W/DATA_W constants.
REQ-026 The PC SHALL be a sub-module pc_counter, providing synchronous clear, increment-enable and wrap.

Verification
REQ-027 Zero-wait fetch: reset, then run=1, mem_rdata=16'hD105, mem_rdy=1 -> mem_rd for 1 cycle at addr 0, then ir=16'hD105, pc=1, exec_start high exactly 1 cycle.
REQ-028 Wait states: mem_rdy held low 3 cycles during FETCH at pc=5 -> mem_rd and mem_addr=5 stable for 4 cycles, ir loaded on the 4th cycle, pc=6.
REQ-029 Store then load:
- In EXEC, ls_req=1, ls_we=1, ls_addr=9'h1A, ls_wdata=16'hBEEF -> mem_wr=1, mem_addr=9'h1A, mem_wdata=16'hBEEF, mem_rd=0, one ls_done, no exec_start.
- Then a load from 9'h1A with mem_rdata=16'hBEEF -> ls_rdata=16'hBEEF.
REQ-030 Simultaneous events: in EXEC, ls_req=1 and exec_done=1 together -> MEM entered and exec_done ignored; a later exec_done with run=0 -> IDLE with no fetch.
REQ-031 Boundaries: pc=9'h1FF fetch -> pc wraps to 0. Reset asserted mid-MEM with mem_rdy low -> next cycle mem_wr=mem_rd=0, state IDLE, pc=0.
REQ-032 FETCH_HALT_EN: with the macro, fetch 16'hE000 -> halted=1, no exec_start, and run ignored until reset. Without the macro -> exec_start pulses normally.

Source files
------------

// File: rtl/fetch_mem_ctrl_pkg.sv
// Shared types and constants for the fetch/memory controller: state encoding,
// HALT opcode and default bus widths.
package fetch_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_t;

    localparam logic [2:0] HALT_OPCODE = 3'b111;
    localparam int         DEF_ADDR_W  = 9;
    localparam int         DEF_DATA_W  = 16;

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous clear, increment enable, wraps modulo 2^W.
module pc_counter
    import fetch_mem_ctrl_pkg::*;
#(
    parameter int W = DEF_ADDR_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Wrap is implicit: the W-bit add drops the carry out of the top bit.
    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (inc)
            count <= count + W'(1);
    end

endmodule

// File: rtl/fetch_mem_ctrl.sv
// Instruction fetch / load-store memory controller. Define FETCH_HALT_EN to make
// opcode 3'b111 stop the machine in HALT until reset.
module fetch_mem_ctrl
    import fetch_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic              exec_start,
    input  logic              exec_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_done,
    output logic              halted
);

    state_t              state;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                halt_op;
    logic                pc_inc;

`ifdef FETCH_HALT_EN
    assign halt_op = (mem_rdata[DATA_W-1 -: 3] == HALT_OPCODE);
    assign halted  = (state == ST_HALT);
`else
    assign halt_op = 1'b0;
    assign halted  = 1'b0;
`endif

    // The PC advances exactly on the completing beat of a fetch.
    assign pc_inc = (state == ST_FETCH) && mem_rdy;

    pc_counter #(.W(ADDR_W)) u_pc (
        .clk   (clk),
        .clr   (reset),
        .inc   (pc_inc),
        .count (pc)
    );

    // Address mux is driven from registers only, so it is stable across wait states.
    assign mem_addr  = (state == ST_MEM) ? lat_addr : pc;
    assign mem_wdata = mem_wr ? lat_wdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            ir         <= '0;
            ls_rdata   <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            exec_start <= 1'b0;
            ls_done    <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here are overridden by later assignments
            // in the case arms, giving one-cycle pulses without extra logic.
            exec_start <= 1'b0;
            ls_done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state  <= ST_FETCH;
                        mem_rd <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (mem_rdy) begin
                        ir     <= mem_rdata;
                        mem_rd <= 1'b0;
                        if (halt_op) begin
                            state <= ST_HALT;
                        end else begin
                            state      <= ST_EXEC;
                            exec_start <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    // A load/store request wins over a simultaneous exec_done.
                    if (ls_req) begin
                        lat_we    <= ls_we;
                        lat_addr  <= ls_addr;
                        lat_wdata <= ls_wdata;
                        mem_rd    <= !ls_we;
                        mem_wr    <= ls_we;
                        state     <= ST_MEM;
                    end else if (exec_done) begin
                        if (run) begin
                            state  <= ST_FETCH;
                            mem_rd <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_rdy) begin
                        if (!lat_we)
                            ls_rdata <= mem_rdata;
                        ls_done <= 1'b1;
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        state   <= ST_EXEC;
                    end
                end
                default: begin
                    // HALT: only reset leaves this state.
                end
            endcase
        end
    end

endmodule
